// File: rtl/countdown_timer_ctrl.sv
// Countdown timer control: 1 s prescaler, MM:SS set/run/pause/done sequencing.
// Optional macro TIMER_ALARM_TIMEOUT_EN: DONE auto-returns to IDLE after ALARM_SECS ticks.
module countdown_timer_ctrl #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_P,
    input  logic       CLEAR_P,
    input  logic       MIN_P,
    input  logic       SEC_P,
    output logic [6:0] MINUTES,
    output logic [5:0] SECONDS,
    output logic       RUNNING,
    output logic       PAUSED,
    output logic       ALARM
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    MIN_LAST   = 7'(MAX_MIN);

    if (TICK_DIV < 2 || MAX_MIN > 127 || ALARM_SECS < 1) begin : g_bad_config
        $error("countdown_timer_ctrl: invalid TICK_DIV/MAX_MIN/ALARM_SECS");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_nxt;
    logic [6:0]    min_nxt;
    logic [5:0]    sec_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          tick;
    logic          running_nxt, paused_nxt, alarm_nxt;

`ifdef TIMER_ALARM_TIMEOUT_EN
    localparam int unsigned   AW         = $clog2(ALARM_SECS + 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
    logic [AW-1:0] acnt, acnt_nxt;
`endif

    // The prescaler is held at 0 outside counting states, so a match implies a live tick.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            MINUTES <= '0;
            SECONDS <= '0;
            presc   <= '0;
            RUNNING <= 1'b0;
            PAUSED  <= 1'b0;
            ALARM   <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
            acnt    <= '0;
`endif
        end else begin
            state   <= state_nxt;
            MINUTES <= min_nxt;
            SECONDS <= sec_nxt;
            presc   <= presc_nxt;
            RUNNING <= running_nxt;
            PAUSED  <= paused_nxt;
            ALARM   <= alarm_nxt;
`ifdef TIMER_ALARM_TIMEOUT_EN
            acnt    <= acnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        min_nxt   = MINUTES;
        sec_nxt   = SECONDS;
        presc_nxt = '0;
`ifdef TIMER_ALARM_TIMEOUT_EN
        acnt_nxt  = '0;
`endif
        unique case (state)
            IDLE: begin
                if (CLEAR_P) begin
                    min_nxt = '0;
                    sec_nxt = '0;
                end else if (START_P && ({MINUTES, SECONDS} != '0)) begin
                    state_nxt = RUN;
                end else begin
                    if (MIN_P) min_nxt = (MINUTES == MIN_LAST) ? '0 : MINUTES + 7'd1;
                    if (SEC_P) sec_nxt = (SECONDS == 6'd59) ? '0 : SECONDS + 6'd1;
                end
            end
            RUN: begin
                if (CLEAR_P) begin
                    state_nxt = IDLE;
                    min_nxt   = '0;
                    sec_nxt   = '0;
                end else if (START_P) begin
                    state_nxt = PAUSE;
                end else if (tick) begin
                    if (SECONDS != '0) begin
                        sec_nxt = SECONDS - 6'd1;
                        if (MINUTES == '0 && SECONDS == 6'd1) state_nxt = DONE;
                    end else begin
                        min_nxt = MINUTES - 7'd1;
                        sec_nxt = 6'd59;
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            PAUSE: begin
                if (CLEAR_P) begin
                    state_nxt = IDLE;
                    min_nxt   = '0;
                    sec_nxt   = '0;
                end else if (START_P) begin
                    state_nxt = RUN;
                end
            end
            DONE: begin
                min_nxt = '0;
                sec_nxt = '0;
                if (START_P || CLEAR_P) begin
                    state_nxt = IDLE;
`ifdef TIMER_ALARM_TIMEOUT_EN
                end else if (tick) begin
                    if (acnt == ALARM_LAST) state_nxt = IDLE;
                    else acnt_nxt = acnt + 1'b1;
                end else begin
                    presc_nxt = presc + 1'b1;
                    acnt_nxt  = acnt;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running_nxt = (state_nxt == RUN);
        paused_nxt  = (state_nxt == PAUSE);
        alarm_nxt   = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed self-checking bench for countdown_timer_ctrl (TICK_DIV=4, MAX_MIN=99, ALARM_SECS=3).
module tb_countdown_timer_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START_P = 1'b0, CLEAR_P = 1'b0, MIN_P = 1'b0, SEC_P = 1'b0;
    logic [6:0] MINUTES;
    logic [5:0] SECONDS;
    logic       RUNNING, PAUSED, ALARM;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] obs, exp;

    countdown_timer_ctrl #(
        .TICK_DIV  (4),
        .MAX_MIN   (99),
        .ALARM_SECS(3)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START_P(START_P),
        .CLEAR_P(CLEAR_P),
        .MIN_P  (MIN_P),
        .SEC_P  (SEC_P),
        .MINUTES(MINUTES),
        .SECONDS(SECONDS),
        .RUNNING(RUNNING),
        .PAUSED (PAUSED),
        .ALARM  (ALARM)
    );

    always #5 CLK = ~CLK;

    // Advance n clock edges; returns 1 time unit after the last edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulse(input logic s, input logic c, input logic m, input logic sc);
        START_P = s;
        CLEAR_P = c;
        MIN_P   = m;
        SEC_P   = sc;
        step(1);
        START_P = 1'b0;
        CLEAR_P = 1'b0;
        MIN_P   = 1'b0;
        SEC_P   = 1'b0;
    endtask

    // Observed vector layout: {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}
    task automatic test_reset;
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_state: actual=%h expected=%h", obs, exp); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL start_at_zero: actual=%h expected=%h", obs, exp); end
    endtask

    task automatic test_set;
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 61; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd2, 6'd1, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL set_02_01: actual=%h expected=%h", obs, exp); end
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd3, 6'd2, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL set_both_03_02: actual=%h expected=%h", obs, exp); end
        for (int i = 0; i < 96; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd99, 6'd2, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL set_99_02: actual=%h expected=%h", obs, exp); end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd2, 3'b000}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL min_wrap: actual=%h expected=%h", obs, exp); end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL idle_clear: actual=%h expected=%h", obs, exp); end
    endtask

    task automatic test_run_to_done;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd1, 6'd0, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL run_entry: actual=%h expected=%h", obs, exp); end
        step(3);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd1, 6'd0, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL before_first_tick: actual=%h expected=%h", obs, exp); end
        step(1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd59, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL first_tick_00_59: actual=%h expected=%h", obs, exp); end
        step(235);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd1, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL run_00_01: actual=%h expected=%h", obs, exp); end
        step(1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd0, 3'b001}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL done_entry: actual=%h expected=%h", obs, exp); end
    endtask

    task automatic test_done_exit;
`ifdef TIMER_ALARM_TIMEOUT_EN
        step(11);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd0, 3'b001}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL alarm_before_timeout: actual=%h expected=%h", obs, exp); end
        step(1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL alarm_timeout: actual=%h expected=%h", obs, exp); end
`else
        step(100);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd0, 3'b001}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL alarm_held: actual=%h expected=%h", obs, exp); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL done_start_exit: actual=%h expected=%h", obs, exp); end
`endif
    endtask

    task automatic test_pause_on_tick;
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd5, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL pause_on_tick: actual=%h expected=%h", obs, exp); end
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        step(4);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd5, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL pause_frozen: actual=%h expected=%h", obs, exp); end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd5, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL resume_no_early_tick: actual=%h expected=%h", obs, exp); end
        step(1);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd4, 3'b100}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL resume_tick_00_04: actual=%h expected=%h", obs, exp); end
    endtask

    task automatic test_clear_start;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL clear_over_start: actual=%h expected=%h", obs, exp); end
    endtask

    task automatic test_reset_in_pause;
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = {7'd0, 6'd3, 3'b010}; checks++;
        if (obs !== exp) begin errors++; $display("FAIL pause_before_rst: actual=%h expected=%h", obs, exp); end
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        obs = {MINUTES, SECONDS, RUNNING, PAUSED, ALARM}; exp = '0; checks++;
        if (obs !== exp) begin errors++; $display("FAIL rst_in_pause: actual=%h expected=%h", obs, exp); end
    endtask

    initial begin
        test_reset;
        test_set;
        test_run_to_done;
        test_done_exit;
        test_pause_on_tick;
        test_clear_start;
        test_reset_in_pause;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
